// File: rtl/uart_pkg.sv
// Shared definitions for the MMIO UART transmitter.
//   uart_tx_state_t : transmitter FSM state encoding
//   UART_DATA_BITS  : payload bits per frame (8N1)
//   UART_STOP_LEVEL : line level for idle and stop bits
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_STOP_LEVEL = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push         : write push_data when not full (ignored when full)
//   pop          : discard the head entry when not empty (ignored when empty)
//   push_data    : entry to write
//   pop_data     : current head entry, combinational (valid when !empty)
//   count        : number of stored entries, 0..DEPTH
//   full, empty  : decoded from the registered count
// DEPTH must be a power of 2 and >= 2 so the pointers wrap by overflow.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             push_ok;
    logic             pop_ok;

    logic [DEPTH-1:0][WIDTH-1:0] entries;

    assign full    = (count_reg == CNT_FULL);
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = count_reg;

    // Storage: one register per entry, written only when the write pointer
    // selects it. No reset needed since empty entries are never read.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;
            always_ff @(posedge clock) begin
                if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= push_data;
                end
            end
            assign entries[gi] = entry_reg;
        end
    endgenerate

    // Show-ahead: the head entry is visible without a read strobe.
    assign pop_data = entries[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter fed by the core's MMIO byte stores.
//   clock        : system clock, rising edge
//   reset        : asynchronous active-high reset; abandons any frame
//   write_enable : one-cycle byte-store strobe
//   write_data   : byte to transmit
//   fifo_full    : FIFO holds FIFO_DEPTH entries
//   fifo_count   : number of queued bytes
//   overflow     : sticky, set when a write arrives while full
//   busy         : frame in progress or bytes still queued
//   txd          : registered serial output, idle high, LSB first
// CLOCKS_PER_BIT must be >= 2; FIFO_DEPTH must be a power of 2 and >= 2.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 16,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          write_enable,
    input  logic [UART_DATA_BITS-1:0]     write_data,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          busy,
    output logic                          txd
);

    localparam int BAUD_W = $clog2(CLOCKS_PER_BIT);
    localparam int BIT_W  = $clog2(UART_DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    uart_tx_state_t              state_reg, state_next;
    logic [BAUD_W-1:0]           baud_reg, baud_next;
    logic [BIT_W-1:0]            bit_reg, bit_next;
    logic [UART_DATA_BITS-1:0]   shift_reg, shift_next;
    logic                        txd_reg, txd_next;
    logic                        overflow_reg;

    logic                        fifo_pop;
    logic                        fifo_empty;
    logic [UART_DATA_BITS-1:0]   head_data;
    logic                        baud_last;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (write_enable),
        .pop       (fifo_pop),
        .push_data (write_data),
        .pop_data  (head_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign baud_last = (baud_reg == BAUD_LAST);

    // Next-state logic. txd_next is the level of the state being entered,
    // so the txd flop changes on the same edge as the state register.
    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        txd_next   = txd_reg;
        fifo_pop   = 1'b0;

        case (state_reg)
            IDLE: begin
                txd_next = UART_STOP_LEVEL;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = head_data;
                    baud_next  = '0;
                    state_next = START;
                    txd_next   = 1'b0;
                end
            end

            START: begin
                if (baud_last) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                    txd_next   = shift_reg[0];
                end else begin
                    baud_next = baud_reg + BAUD_ONE;
                end
            end

            DATA: begin
                if (baud_last) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[UART_DATA_BITS-1:1]};
                    if (bit_reg == BIT_LAST) begin
                        state_next = STOP;
                        txd_next   = UART_STOP_LEVEL;
                    end else begin
                        bit_next = bit_reg + BIT_ONE;
                        txd_next = shift_reg[1];
                    end
                end else begin
                    baud_next = baud_reg + BAUD_ONE;
                end
            end

            STOP: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (!fifo_empty) begin
                        // Back-to-back frame: no idle cycle between stop and start.
                        fifo_pop   = 1'b1;
                        shift_next = head_data;
                        state_next = START;
                        txd_next   = 1'b0;
                    end else begin
                        state_next = IDLE;
                        txd_next   = UART_STOP_LEVEL;
                    end
                end else begin
                    baud_next = baud_reg + BAUD_ONE;
                end
            end

            default: begin
                state_next = IDLE;
                baud_next  = '0;
                txd_next   = UART_STOP_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            baud_reg     <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            txd_reg      <= UART_STOP_LEVEL;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            txd_reg   <= txd_next;
            // fifo_full comes from the registered count, so a write in a
            // pop cycle while full is still dropped and flagged.
            if (write_enable && fifo_full) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign txd      = txd_reg;
    assign overflow = overflow_reg;
    assign busy     = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with CLOCKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic       clock;
    logic       reset;
    logic       write_enable;
    logic [7:0] write_data;
    logic       fifo_full;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       busy;
    logic       txd;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Decoded serial stream: bytes, start-bit cycle, stop-bit level.
    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic       rx_s[$];

    mmio_uart_tx #(
        .CLOCKS_PER_BIT (CPB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .write_enable (write_enable),
        .write_data   (write_data),
        .fifo_full    (fifo_full),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .busy         (busy),
        .txd          (txd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Serial monitor: samples each bit in its middle cycle.
    initial begin
        int         mpos;
        bit         mact;
        int         mstart;
        logic [7:0] msh;
        logic       mstop;
        mact = 0; mpos = 0; mstart = 0; msh = '0; mstop = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                mact = 0;
            end else if (!mact) begin
                if (txd == 1'b0) begin
                    mact = 1; mpos = 0; mstart = cyc;
                end
            end else begin
                mpos++;
                if ((mpos % CPB) == CPB / 2 && (mpos / CPB) >= 1 && (mpos / CPB) <= 8)
                    msh[(mpos / CPB) - 1] = txd;
                if (mpos == 9 * CPB + CPB / 2)
                    mstop = txd;
                if (mpos == 10 * CPB - 1) begin
                    rx_q.push_back(msh);
                    rx_t.push_back(mstart);
                    rx_s.push_back(mstop);
                    mact = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, act, exp_v, cyc);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        write_enable = 1'b1;
        write_data   = d;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            tick();
            n++;
        end
        check("idle_wait_busy", int'(busy), 0);
        tick();
        tick();
    endtask

    task automatic expect_rx(input string nm, input logic [7:0] exp_b);
        if (rx_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got=none want=%0h", nm, exp_b);
        end else begin
            check(nm, int'(rx_q.pop_front()), int'(exp_b));
            void'(rx_t.pop_front());
            check({nm, "_stop"}, int'(rx_s.pop_front()), 1);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // bit 0 = start bit, bit 9 = stop bit
    } vec_t;

    vec_t vecs[5];

    initial begin
        int t0;
        int t1;

        vecs[0] = '{data: 8'h55, frame: 10'h2AA};
        vecs[1] = '{data: 8'h01, frame: 10'h202};
        vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
        vecs[3] = '{data: 8'h80, frame: 10'h300};
        vecs[4] = '{data: 8'hA5, frame: 10'h34A};

        reset        = 1'b1;
        write_enable = 1'b0;
        write_data   = 8'h00;
        tick();
        tick();
        check("rst_txd", int'(txd), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_full", int'(fifo_full), 0);
        check("rst_ovf", int'(overflow), 0);
        #2 reset = 1'b0;
        tick();
        tick();

        // Table: one byte per vector, txd checked every cycle of the frame.
        for (int v = 0; v < 5; v++) begin
            wr(vecs[v].data);
            check("vec_count_after_push", int'(fifo_count), 1);
            for (int k = 1; k <= 10 * CPB; k++) begin
                tick();
                check($sformatf("vec%0d_txd_c%0d", v, k), int'(txd), int'(vecs[v].frame[(k - 1) / CPB]));
                if (k == 1) check("vec_count_after_pop", int'(fifo_count), 0);
            end
            check("vec_busy_last_stop", int'(busy), 1);
            tick();
            check("vec_busy_fall", int'(busy), 0);
            check("vec_txd_idle", int'(txd), 1);
            tick();
            tick();
            expect_rx($sformatf("vec%0d_rx", v), vecs[v].data);
        end

        // Back-to-back frames.
        wr(8'hA5);
        wr(8'h3C);
        wait_idle(400);
        if (rx_t.size() >= 2) begin
            t0 = rx_t[0];
            t1 = rx_t[1];
            check("b2b_start_gap", t1 - t0, 10 * CPB);
        end else begin
            total++; bad++;
            $display("FAIL b2b_frames: got=%0d want=2", rx_t.size());
        end
        expect_rx("b2b_rx0", 8'hA5);
        expect_rx("b2b_rx1", 8'h3C);

        // Push during the last STOP cycle with count=3.
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        wr(8'h44);
        check("pp_count3", int'(fifo_count), 3);
        repeat (37) tick();
        check("pp_txd_stop", int'(txd), 1);
        check("pp_count_before", int'(fifo_count), 3);
        wr(8'h7E);
        check("pp_count_after", int'(fifo_count), 3);
        check("pp_next_start", int'(txd), 0);
        wait_idle(1000);
        expect_rx("pp_rx0", 8'h11);
        expect_rx("pp_rx1", 8'h22);
        expect_rx("pp_rx2", 8'h33);
        expect_rx("pp_rx3", 8'h44);
        expect_rx("pp_rx4", 8'h7E);

        // Overflow: ten consecutive writes from idle.
        for (int i = 0; i < 10; i++) begin
            write_enable = 1'b1;
            write_data   = 8'h30 + 8'(i);
            tick();
            if (i == 8) begin
                check("ovf_count8", int'(fifo_count), 8);
                check("ovf_full", int'(fifo_full), 1);
                check("ovf_not_yet", int'(overflow), 0);
            end
            if (i == 9) begin
                check("ovf_set", int'(overflow), 1);
                check("ovf_count_held", int'(fifo_count), 8);
            end
        end
        write_enable = 1'b0;
        wait_idle(1000);
        check("ovf_sticky", int'(overflow), 1);
        check("ovf_count0", int'(fifo_count), 0);
        check("ovf_full0", int'(fifo_full), 0);
        for (int i = 0; i < 9; i++) begin
            expect_rx($sformatf("ovf_rx%0d", i), 8'h30 + 8'(i));
        end
        check("ovf_no_extra", rx_q.size(), 0);

        // Reset during DATA bit 3.
        wr(8'hFF);
        wr(8'h80);
        repeat (17) tick();
        check("mr_count_before", int'(fifo_count), 1);
        check("mr_busy_before", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check("mr_txd", int'(txd), 1);
        check("mr_busy", int'(busy), 0);
        check("mr_count", int'(fifo_count), 0);
        check("mr_full", int'(fifo_full), 0);
        check("mr_ovf", int'(overflow), 0);
        tick();
        tick();
        #2 reset = 1'b0;
        rx_q.delete();
        rx_t.delete();
        rx_s.delete();
        tick();
        wr(8'h01);
        tick();
        check("mr_new_start", int'(txd), 0);
        wait_idle(400);
        expect_rx("mr_rx", 8'h01);
        check("mr_no_extra", rx_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
